// File: rtl/vt52_cmd_engine_if.sv
// Byte-stream and memory/cursor bus between the UART receive path and vt52_cmd_engine.
// The engine connects through the slave modport; the byte source and memories use master.
interface vt52_cmd_engine_if #(
    parameter int unsigned COL_W = 7,
    parameter int unsigned ROW_W = 5
);
    logic             mem_ready;
    logic [7:0]       data;
    logic             valid;
    logic             ready;
    logic [7:0]       wr_char;
    logic [COL_W-1:0] wr_x;
    logic [ROW_W-1:0] wr_y;
    logic             wr_en;
    logic [COL_W-1:0] cursor_x;
    logic [ROW_W-1:0] cursor_y;
    logic             cursor_wen;
    logic             scroll;

    modport master (
        output mem_ready, data, valid,
        input  ready, wr_char, wr_x, wr_y, wr_en, cursor_x, cursor_y, cursor_wen, scroll
    );

    modport slave (
        input  mem_ready, data, valid,
        output ready, wr_char, wr_x, wr_y, wr_en, cursor_x, cursor_y, cursor_wen, scroll
    );
endinterface

// File: rtl/vt52_cmd_engine.sv
// VT52 command interpreter: printable writes, cursor motion, ESC Y addressing, scroll requests.
// Define CMD_ERASE_EN to compile in the multi-cycle ESC J / ESC K erase engine.
module vt52_cmd_engine #(
    parameter int unsigned COLS  = 80,
    parameter int unsigned ROWS  = 24,
    parameter int unsigned COL_W = 7,
    parameter int unsigned ROW_W = 5
) (
    input  logic              clk,
    input  logic              clr,
    vt52_cmd_engine_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ESC,
        S_ESC_Y_ROW,
        S_ESC_Y_COL
`ifdef CMD_ERASE_EN
        , S_ERASE
`endif
    } state_t;

    localparam logic [COL_W-1:0] X_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] Y_MAX = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] X_ONE = COL_W'(1);
    localparam logic [ROW_W-1:0] Y_ONE = ROW_W'(1);

    state_t           state, state_nxt;
    logic [COL_W-1:0] cx, cx_nxt;
    logic [ROW_W-1:0] cy, cy_nxt;
    logic [7:0]       row_lat, row_lat_nxt;
    logic [7:0]       wr_char_q, wr_char_nxt;
    logic [COL_W-1:0] wr_x_q, wr_x_nxt;
    logic [ROW_W-1:0] wr_y_q, wr_y_nxt;
    logic             wr_en_q, wr_en_nxt;
    logic             cwen_q, cwen_nxt;
    logic             scroll_q, scroll_nxt;
    logic             force_cwen;
    logic             ready_i;
    logic             accept;
    logic [7:0]       arg;
    logic [COL_W:0]   tab_n;

`ifdef CMD_ERASE_EN
    logic [COL_W-1:0] ex, ex_nxt;
    logic [ROW_W-1:0] ey, ey_nxt;
    logic             erase_screen, erase_screen_nxt;

    assign ready_i = bus.mem_ready && (state != S_ERASE);
`else
    assign ready_i = bus.mem_ready;
`endif

    assign accept = bus.valid && ready_i;
    assign arg    = bus.data - 8'h20;
    // Next tab stop, one bit wider than the cursor so a stop past the last column stays visible
    assign tab_n  = ({1'b0, cx} + (COL_W+1)'(8)) & ~((COL_W+1)'(7));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= S_IDLE;
            cx        <= '0;
            cy        <= '0;
            row_lat   <= '0;
            wr_char_q <= '0;
            wr_x_q    <= '0;
            wr_y_q    <= '0;
            wr_en_q   <= 1'b0;
            cwen_q    <= 1'b0;
            scroll_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cx        <= cx_nxt;
            cy        <= cy_nxt;
            row_lat   <= row_lat_nxt;
            wr_char_q <= wr_char_nxt;
            wr_x_q    <= wr_x_nxt;
            wr_y_q    <= wr_y_nxt;
            wr_en_q   <= wr_en_nxt;
            cwen_q    <= cwen_nxt;
            scroll_q  <= scroll_nxt;
        end
    end

`ifdef CMD_ERASE_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ex           <= '0;
            ey           <= '0;
            erase_screen <= 1'b0;
        end else begin
            ex           <= ex_nxt;
            ey           <= ey_nxt;
            erase_screen <= erase_screen_nxt;
        end
    end
`endif

    always_comb begin
        state_nxt   = state;
        cx_nxt      = cx;
        cy_nxt      = cy;
        row_lat_nxt = row_lat;
        wr_char_nxt = wr_char_q;
        wr_x_nxt    = wr_x_q;
        wr_y_nxt    = wr_y_q;
        wr_en_nxt   = 1'b0;
        scroll_nxt  = 1'b0;
        force_cwen  = 1'b0;
`ifdef CMD_ERASE_EN
        ex_nxt           = ex;
        ey_nxt           = ey;
        erase_screen_nxt = erase_screen;
`endif

        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (bus.data >= 8'h20 && bus.data <= 8'h7E) begin
                        wr_en_nxt   = 1'b1;
                        wr_char_nxt = bus.data;
                        wr_x_nxt    = cx;
                        wr_y_nxt    = cy;
                        if (cx < X_MAX) cx_nxt = cx + X_ONE;
                    end else begin
                        case (bus.data)
                            8'h08: if (cx != '0) cx_nxt = cx - X_ONE;
                            8'h09: begin
                                if (tab_n <= {1'b0, X_MAX}) cx_nxt = tab_n[COL_W-1:0];
                                else if (cx < X_MAX)        cx_nxt = cx + X_ONE;
                            end
                            8'h0A: begin
                                if (cy < Y_MAX) cy_nxt = cy + Y_ONE;
                                else            scroll_nxt = 1'b1;
                            end
                            8'h0D: cx_nxt = '0;
                            8'h1B: state_nxt = S_ESC;
                            default: ;
                        endcase
                    end
                end
            end

            S_ESC: begin
                if (accept) begin
                    state_nxt = S_IDLE;
                    case (bus.data)
                        8'h41: if (cy != '0) cy_nxt = cy - Y_ONE;
                        8'h42: if (cy < Y_MAX) cy_nxt = cy + Y_ONE;
                        8'h43: if (cx < X_MAX) cx_nxt = cx + X_ONE;
                        8'h44: if (cx != '0) cx_nxt = cx - X_ONE;
                        8'h48: begin
                            cx_nxt = '0;
                            cy_nxt = '0;
                        end
                        8'h59: state_nxt = S_ESC_Y_ROW;
                        8'h1B: state_nxt = S_ESC;
`ifdef CMD_ERASE_EN
                        8'h4A, 8'h4B: begin
                            state_nxt        = S_ERASE;
                            ex_nxt           = cx;
                            ey_nxt           = cy;
                            erase_screen_nxt = (bus.data == 8'h4A);
                        end
`endif
                        default: ;
                    endcase
                end
            end

            S_ESC_Y_ROW: begin
                if (accept) begin
                    row_lat_nxt = arg;
                    state_nxt   = S_ESC_Y_COL;
                end
            end

            S_ESC_Y_COL: begin
                if (accept) begin
                    // Bytes below 0x20 wrap to large values and land in the out-of-range branches
                    if (row_lat < 8'(ROWS)) cy_nxt = ROW_W'(row_lat);
                    cx_nxt     = (arg > 8'(COLS - 1)) ? X_MAX : COL_W'(arg);
                    force_cwen = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end

`ifdef CMD_ERASE_EN
            S_ERASE: begin
                if (bus.mem_ready) begin
                    wr_en_nxt   = 1'b1;
                    wr_char_nxt = 8'h20;
                    wr_x_nxt    = ex;
                    wr_y_nxt    = ey;
                    if (ex == X_MAX) begin
                        if (!erase_screen || ey == Y_MAX) begin
                            state_nxt = S_IDLE;
                        end else begin
                            ex_nxt = '0;
                            ey_nxt = ey + Y_ONE;
                        end
                    end else begin
                        ex_nxt = ex + X_ONE;
                    end
                end
            end
`endif

            default: state_nxt = S_IDLE;
        endcase

        cwen_nxt = accept && (force_cwen || (cx_nxt != cx) || (cy_nxt != cy));
    end

    assign bus.ready      = ready_i;
    assign bus.wr_char    = wr_char_q;
    assign bus.wr_x       = wr_x_q;
    assign bus.wr_y       = wr_y_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.cursor_x   = cx;
    assign bus.cursor_y   = cy;
    assign bus.cursor_wen = cwen_q;
    assign bus.scroll     = scroll_q;

endmodule

// File: tb/tb_vt52_cmd_engine.sv
// Directed self-checking bench for vt52_cmd_engine at 80x24; erase checks follow CMD_ERASE_EN.
module tb_vt52_cmd_engine;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    vt52_cmd_engine_if #(.COL_W(7), .ROW_W(5)) bus ();

    vt52_cmd_engine #(.COLS(80), .ROWS(24), .COL_W(7), .ROW_W(5)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte for exactly one accepting edge; outputs are then sampled 1 ns after it
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.data      = b;
        bus.valid     = 1'b1;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic goto_xy(input logic [7:0] x, input logic [7:0] y);
        send(8'h1B);
        send(8'h59);
        send(8'h20 + y);
        send(8'h20 + x);
    endtask

    int         writes;
    int         cyc;
    int         ready_high;
    int         bad_char;
    int         moved;
    int         extra;
    logic [7:0] first_x, first_y, last_x, last_y;

    initial begin
        bus.mem_ready = 1'b0;
        bus.data      = 8'h00;
        bus.valid     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_char", bus.wr_char, 0);
        check("rst_wr_x", bus.wr_x, 0);
        check("rst_wr_y", bus.wr_y, 0);
        check("rst_cursor_x", bus.cursor_x, 0);
        check("rst_cursor_y", bus.cursor_y, 0);
        check("rst_cursor_wen", bus.cursor_wen, 0);
        check("rst_scroll", bus.scroll, 0);
        check("rst_ready_lo", bus.ready, 0);
        bus.mem_ready = 1'b1;
        #1;
        check("rst_ready_hi", bus.ready, 1);
        @(negedge clk);
        clr = 1'b0;

        send(8'h41);
        check("A_wr_en", bus.wr_en, 1);
        check("A_char", bus.wr_char, 8'h41);
        check("A_x", bus.wr_x, 0);
        check("A_y", bus.wr_y, 0);
        check("A_cwen", bus.cursor_wen, 1);
        check("A_cursor_x", bus.cursor_x, 1);
        send(8'h42);
        check("B_wr_en", bus.wr_en, 1);
        check("B_char", bus.wr_char, 8'h42);
        check("B_x", bus.wr_x, 1);
        check("B_cursor_x", bus.cursor_x, 2);
        idle_cycle();
        check("strobe_drop_wr_en", bus.wr_en, 0);
        check("strobe_drop_cwen", bus.cursor_wen, 0);

        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check("ready_follows_mem", bus.ready, 0);
        bus.mem_ready = 1'b1;

        goto_xy(8'd79, 8'd0);
        check("escY_79_x", bus.cursor_x, 79);
        check("escY_79_cwen", bus.cursor_wen, 1);
        send(8'h5A);
        check("Z_wr_en", bus.wr_en, 1);
        check("Z_wr_x", bus.wr_x, 79);
        check("Z_cwen", bus.cursor_wen, 0);
        check("Z_cursor_x", bus.cursor_x, 79);

        send(8'h1B); send(8'h59); send(8'h25); send(8'h2A);
        check("escY_10_5_x", bus.cursor_x, 10);
        check("escY_10_5_y", bus.cursor_y, 5);
        check("escY_10_5_cwen", bus.cursor_wen, 1);
        send(8'h1B); send(8'h59); send(8'h7F); send(8'h7F);
        check("escY_oor_y", bus.cursor_y, 5);
        check("escY_oor_x", bus.cursor_x, 79);
        check("escY_oor_cwen", bus.cursor_wen, 1);
        send(8'h1B); send(8'h59); send(8'h25); send(8'h2A);
        send(8'h1B); send(8'h59); send(8'h25); send(8'h2A);
        check("escY_same_cwen", bus.cursor_wen, 1);

        send(8'h08);
        check("bs_x", bus.cursor_x, 9);
        send(8'h0D);
        check("cr_x", bus.cursor_x, 0);
        check("cr_cwen", bus.cursor_wen, 1);
        send(8'h0D);
        check("cr_again_cwen", bus.cursor_wen, 0);
        send(8'h08);
        check("bs_at0_cwen", bus.cursor_wen, 0);

        goto_xy(8'd0, 8'd23);
        send(8'h0A);
        check("lf_bottom_scroll", bus.scroll, 1);
        check("lf_bottom_y", bus.cursor_y, 23);
        check("lf_bottom_cwen", bus.cursor_wen, 0);
        idle_cycle();
        check("scroll_one_cycle", bus.scroll, 0);
        send(8'h1B); send(8'h42);
        check("escB_bottom_scroll", bus.scroll, 0);
        check("escB_bottom_y", bus.cursor_y, 23);
        check("escB_bottom_cwen", bus.cursor_wen, 0);
        send(8'h1B); send(8'h41);
        check("escA_y", bus.cursor_y, 22);
        send(8'h0A);
        check("lf_y", bus.cursor_y, 23);
        check("lf_noscroll", bus.scroll, 0);
        send(8'h1B); send(8'h48);
        check("home_x", bus.cursor_x, 0);
        check("home_y", bus.cursor_y, 0);
        send(8'h1B); send(8'h41);
        check("escA_top_cwen", bus.cursor_wen, 0);
        send(8'h1B); send(8'h44);
        check("escD_left_cwen", bus.cursor_wen, 0);
        send(8'h1B); send(8'h1B); send(8'h43);
        check("esc_esc_C_x", bus.cursor_x, 1);
        send(8'h1B); send(8'h5A); send(8'h51);
        check("esc_unrec_then_Q", bus.wr_char, 8'h51);
        check("esc_unrec_then_Q_x", bus.wr_x, 1);

        send(8'h0D);
        send(8'h09);
        check("tab_0", bus.cursor_x, 8);
        goto_xy(8'd73, 8'd0);
        send(8'h09);
        check("tab_73", bus.cursor_x, 74);
        goto_xy(8'd79, 8'd0);
        send(8'h09);
        check("tab_79", bus.cursor_x, 79);
        check("tab_79_cwen", bus.cursor_wen, 0);
        send(8'h1B); send(8'h43);
        check("escC_right_x", bus.cursor_x, 79);

`ifdef CMD_ERASE_EN
        goto_xy(8'd78, 8'd22);
        send(8'h1B); send(8'h4A);
        check("escJ_no_write_on_accept", bus.wr_en, 0);
        writes = 0; cyc = 0; ready_high = 0; bad_char = 0; moved = 0;
        first_x = 0; first_y = 0; last_x = 0; last_y = 0;
        while (writes < 82 && cyc < 2000) begin
            @(negedge clk);
            bus.mem_ready = ((cyc % 3) != 1);
            #1;
            if (bus.ready) ready_high++;
            @(posedge clk);
            #1;
            cyc++;
            if (bus.cursor_x != 7'd78 || bus.cursor_y != 5'd22) moved++;
            if (bus.wr_en) begin
                if (writes == 0) begin
                    first_x = 8'(bus.wr_x);
                    first_y = 8'(bus.wr_y);
                end
                last_x = 8'(bus.wr_x);
                last_y = 8'(bus.wr_y);
                if (bus.wr_char != 8'h20) bad_char++;
                writes++;
            end
        end
        check("escJ_writes", writes, 82);
        check("escJ_ready_low", ready_high, 0);
        check("escJ_chars", bad_char, 0);
        check("escJ_cursor_still", moved, 0);
        check("escJ_first_x", first_x, 78);
        check("escJ_first_y", first_y, 22);
        check("escJ_last_x", last_x, 79);
        check("escJ_last_y", last_y, 23);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        extra = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.wr_en) extra++;
        end
        check("escJ_no_extra", extra, 0);
        check("escJ_ready_back", bus.ready, 1);

        goto_xy(8'd5, 8'd3);
        send(8'h1B); send(8'h4B);
        repeat (10) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        #1;
        check("clr_erase_wr_en", bus.wr_en, 0);
        check("clr_erase_wr_char", bus.wr_char, 0);
        check("clr_erase_wr_x", bus.wr_x, 0);
        check("clr_erase_wr_y", bus.wr_y, 0);
        check("clr_erase_cursor_x", bus.cursor_x, 0);
        check("clr_erase_cursor_y", bus.cursor_y, 0);
        check("clr_erase_ready", bus.ready, 1);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        check("clr_erase_no_resume", bus.wr_en, 0);
`else
        goto_xy(8'd78, 8'd22);
        send(8'h1B); send(8'h4A);
        extra = 0;
        ready_high = 0;
        if (bus.wr_en) extra++;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.wr_en) extra++;
            if (bus.ready) ready_high++;
        end
        check("escJ_off_no_writes", extra, 0);
        check("escJ_off_ready", ready_high, 5);
        check("escJ_off_cursor_x", bus.cursor_x, 78);
        check("escJ_off_cursor_y", bus.cursor_y, 22);
        send(8'h51);
        check("escJ_off_idle_write", bus.wr_en, 1);
        check("escJ_off_idle_x", bus.wr_x, 78);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
